// File: rtl/gru_pkg.sv
// Shared types and constants for the GRU gate linear stage and its result collector.
package gru_pkg;

    localparam int          DW       = 32;
    localparam int          NPAIR_Z  = 16;
    localparam int          NPAIR_RH = 32;
    localparam logic [6:0]  BASE_Z   = 7'h00;
    localparam logic [6:0]  BASE_RH  = 7'h20;

    typedef logic [DW-1:0] word_t;
    typedef word_t         vec32_t [31:0];

    typedef enum logic [1:0] {
        COL_IDLE    = 2'd0,
        COL_COLLECT = 2'd1,
        COL_HOLD    = 2'd2
    } col_state_e;

    // Pair index of the final done pulse for a pass of the given kind.
    function automatic logic [4:0] last_pair(input logic kind);
        return kind ? 5'(NPAIR_RH - 1) : 5'(NPAIR_Z - 1);
    endfunction

endpackage

// File: rtl/uarr_linear_result_collector_2ports_pair_deinterleave_buf.sv
// 64-word result buffer: each write stores an even/odd row pair at word 2*idx and 2*idx+1.
// Words 0..31 form the low view, words 32..63 the high view.
module uarr_linear_result_collector_2ports_pair_deinterleave_buf
    import gru_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [4:0]        i_wr_idx,
    input  logic [DW-1:0]     i_wr_even,
    input  logic [DW-1:0]     i_wr_odd,
    output logic [32*DW-1:0]  o_lo,
    output logic [32*DW-1:0]  o_hi
);

    vec32_t r_lo;
    vec32_t r_hi;

    logic [4:0] w_even_addr;
    logic [4:0] w_odd_addr;

    assign w_even_addr = {i_wr_idx[3:0], 1'b0};
    assign w_odd_addr  = {i_wr_idx[3:0], 1'b1};

    // Pair write; pair index bit 4 selects the upper half of the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_lo[i] <= '0;
                r_hi[i] <= '0;
            end
        end else if (i_wr_en) begin
            if (i_wr_idx[4]) begin
                r_hi[w_even_addr] <= i_wr_even;
                r_hi[w_odd_addr]  <= i_wr_odd;
            end else begin
                r_lo[w_even_addr] <= i_wr_even;
                r_lo[w_odd_addr]  <= i_wr_odd;
            end
        end
    end

    // Flatten both views, word 0 in the least significant bits.
    always_comb begin
        o_lo = '0;
        o_hi = '0;
        for (int i = 0; i < 32; i++) begin
            o_lo[i*DW +: DW] = r_lo[i];
            o_hi[i*DW +: DW] = r_hi[i];
        end
    end

endmodule

// File: rtl/uarr_linear_result_collector_2ports.sv
// Receive end of the 2-port gate linear stage: collects even/odd result pairs into
// contiguous z or r/h vectors and presents them over a valid/ready handshake.
module uarr_linear_result_collector_2ports
    import gru_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [6:0]        i_base_in,
    output logic              o_start_ready,
    input  logic              i_done_in,
    input  logic [DW-1:0]     i_din1,
    input  logic [DW-1:0]     i_din2,
    output logic              o_vec_valid,
    input  logic              i_vec_ready,
    output logic              o_vec_kind,
    output logic [32*DW-1:0]  o_vec_lo,
    output logic [32*DW-1:0]  o_vec_hi,
    output logic              o_busy,
    output logic              o_err
);

    col_state_e r_state;
    logic [4:0] r_pair_cnt;
    logic [4:0] r_last_pair;
    logic       r_kind;
    logic       r_vec_valid;
    logic       r_busy;
    logic       r_err;

    logic              w_base_legal;
    logic              w_base_kind;
    logic              w_wr_en;
    logic [32*DW-1:0]  w_buf_lo;
    logic [32*DW-1:0]  w_buf_hi;

    assign w_base_legal = (i_base_in == BASE_Z) || (i_base_in == BASE_RH);
    assign w_base_kind  = (i_base_in == BASE_RH);
    assign w_wr_en      = (r_state == COL_COLLECT) && i_done_in;

    uarr_linear_result_collector_2ports_pair_deinterleave_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_pair_cnt),
        .i_wr_even (i_din1),
        .i_wr_odd  (i_din2),
        .o_lo      (w_buf_lo),
        .o_hi      (w_buf_hi)
    );

    // Collector FSM with pair counter, registered status outputs and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= COL_IDLE;
            r_pair_cnt  <= '0;
            r_last_pair <= '0;
            r_kind      <= 1'b0;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                COL_IDLE: begin
                    if (i_done_in) begin
                        r_err <= 1'b1;
                    end
                    if (i_start) begin
                        if (w_base_legal) begin
                            r_state     <= COL_COLLECT;
                            r_kind      <= w_base_kind;
                            r_last_pair <= last_pair(w_base_kind);
                            r_pair_cnt  <= '0;
                            r_busy      <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                COL_COLLECT: begin
                    if (i_start) begin
                        r_err <= 1'b1;
                    end
                    if (i_done_in) begin
                        if (r_pair_cnt == r_last_pair) begin
                            r_state     <= COL_HOLD;
                            r_pair_cnt  <= '0;
                            r_vec_valid <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_pair_cnt <= r_pair_cnt + 5'd1;
                        end
                    end
                end
                COL_HOLD: begin
                    if (i_done_in) begin
                        r_err <= 1'b1;
                    end
                    if (i_vec_ready) begin
                        r_vec_valid <= 1'b0;
                        if (i_start && w_base_legal) begin
                            r_state     <= COL_COLLECT;
                            r_kind      <= w_base_kind;
                            r_last_pair <= last_pair(w_base_kind);
                            r_pair_cnt  <= '0;
                            r_busy      <= 1'b1;
                        end else begin
                            r_state <= COL_IDLE;
                            if (i_start) begin
                                r_err <= 1'b1;
                            end
                        end
                    end else if (i_start) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= COL_IDLE;
                    r_vec_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Output views: data only while a set is presented; high half masked for z sets.
    always_comb begin
        o_vec_lo = r_vec_valid ? w_buf_lo : '0;
        o_vec_hi = (r_vec_valid && r_kind) ? w_buf_hi : '0;
    end

    assign o_start_ready = (r_state == COL_IDLE) || ((r_state == COL_HOLD) && i_vec_ready);
    assign o_vec_valid   = r_vec_valid;
    assign o_vec_kind    = r_vec_valid && r_kind;
    assign o_busy        = r_busy;
    assign o_err         = r_err;

endmodule
